// File: rtl/cmd_aggregator_pkg.sv
// Shared types and constants for the UART command front end and its dispatcher.
package cmd_aggregator_pkg;

    localparam int unsigned CMD_BYTES = 3;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CMD_W     = CMD_BYTES * BYTE_W;

    localparam logic [BYTE_W-1:0] RESP_ACK  = 8'hA5;
    localparam logic [BYTE_W-1:0] RESP_NACK = 8'hEE;

    typedef enum logic [1:0] {B0, B1, B2, FULL} rx_state_e;
    typedef enum logic {TX_IDLE, TX_WAIT} tx_state_e;

endpackage

// File: rtl/cmd_aggregator_resp_tx_queue.sv
// Response path to the UART transmitter: one byte in flight plus a one-entry holding slot.
module resp_tx_queue
    import cmd_aggregator_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send_resp_i,
    input  logic [BYTE_W-1:0] resp_data_i,
    input  logic              tx_done_i,
    output logic [BYTE_W-1:0] tx_data_o,
    output logic              trmt_o,
    output logic              resp_sent_o,
    output logic              resp_overrun_o
);

    tx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [BYTE_W-1:0] slot_q, slot_d;
    logic              slot_vld_q, slot_vld_d;
    logic              trmt_q, trmt_d;
    logic              sent_q, sent_d;
    logic              overrun_q, overrun_d;
    logic              bypass_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TX_IDLE;
            tx_data_q  <= '0;
            slot_q     <= '0;
            slot_vld_q <= 1'b0;
            trmt_q     <= 1'b0;
            sent_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            slot_q     <= slot_d;
            slot_vld_q <= slot_vld_d;
            trmt_q     <= trmt_d;
            sent_q     <= sent_d;
            overrun_q  <= overrun_d;
        end
    end

    // A request arriving with tx_done and an empty slot skips the slot and starts at once.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        slot_d     = slot_q;
        slot_vld_d = slot_vld_q;
        trmt_d     = 1'b0;
        sent_d     = 1'b0;
        overrun_d  = overrun_q;
        bypass_c   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (send_resp_i) begin
                    tx_data_d = resp_data_i;
                    trmt_d    = 1'b1;
                    state_d   = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (tx_done_i) begin
                    sent_d = 1'b1;
                    if (slot_vld_q) begin
                        tx_data_d  = slot_q;
                        trmt_d     = 1'b1;
                        slot_vld_d = 1'b0;
                    end else if (send_resp_i) begin
                        tx_data_d = resp_data_i;
                        trmt_d    = 1'b1;
                        bypass_c  = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
                if (send_resp_i && !bypass_c) begin
                    if (slot_vld_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        slot_d     = resp_data_i;
                        slot_vld_d = 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign tx_data_o      = tx_data_q;
    assign trmt_o         = trmt_q;
    assign resp_sent_o    = sent_q;
    assign resp_overrun_o = overrun_q;

endmodule

// File: rtl/cmd_aggregator.sv
// UART-side command front end: assembles 3 rx bytes into a 24-bit command with an
// inter-byte timeout, and forwards dispatcher responses to the transmitter.
module cmd_aggregator
    import cmd_aggregator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_rdy,
    output logic              clr_rx_rdy,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    input  logic [BYTE_W-1:0] resp_data,
    input  logic              send_resp,
    output logic              resp_sent,
    output logic [BYTE_W-1:0] tx_data,
    output logic              trmt,
    input  logic              tx_done,
    output logic              resp_overrun
);

    localparam int unsigned    TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    rx_state_e        state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             clr_q, clr_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             take_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= B0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            clr_q     <= 1'b0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            clr_q     <= clr_d;
            tmr_q     <= tmr_d;
        end
    end

    // rx_rdy is still high while our clear pulse is out, so it is ignored that cycle.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        clr_d     = 1'b0;
        tmr_d     = tmr_q;
        take_c    = rx_rdy && !clr_q;
        case (state_q)
            B0: begin
                tmr_d = '0;
                if (take_c) begin
                    cmd_d[CMD_W-1 -: BYTE_W] = rx_data;
                    clr_d   = 1'b1;
                    state_d = B1;
                end
            end
            B1, B2: begin
                if (tmr_q == TMR_LAST) begin
                    // Partial command dropped; a byte arriving now starts a fresh one.
                    state_d = B0;
                    tmr_d   = '0;
                    if (take_c) begin
                        cmd_d[CMD_W-1 -: BYTE_W] = rx_data;
                        clr_d   = 1'b1;
                        state_d = B1;
                    end
                end else if (take_c) begin
                    clr_d = 1'b1;
                    tmr_d = '0;
                    if (state_q == B1) begin
                        cmd_d[2*BYTE_W-1 -: BYTE_W] = rx_data;
                        state_d = B2;
                    end else begin
                        cmd_d[BYTE_W-1:0] = rx_data;
                        cmd_rdy_d = 1'b1;
                        state_d   = FULL;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            FULL: begin
                tmr_d = '0;
                if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = B0;
                end
            end
            default: state_d = B0;
        endcase
    end

    assign clr_rx_rdy = clr_q;
    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;

    resp_tx_queue u_resp_tx_queue (
        .clk            (clk),
        .rst_n          (rst_n),
        .send_resp_i    (send_resp),
        .resp_data_i    (resp_data),
        .tx_done_i      (tx_done),
        .tx_data_o      (tx_data),
        .trmt_o         (trmt),
        .resp_sent_o    (resp_sent),
        .resp_overrun_o (resp_overrun)
    );

endmodule

// File: tb/tb_cmd_aggregator.sv
// Directed bench for cmd_aggregator: cycle-level behavioural model plus literal checkpoints.
module tb_cmd_aggregator;
    import cmd_aggregator_pkg::*;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp_data = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done = 1'b0;
    logic        resp_overrun;

    cmd_aggregator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp_data(resp_data), .send_resp(send_resp), .resp_sent(resp_sent),
        .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done), .resp_overrun(resp_overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    int clr_cnt = 0;
    logic [7:0] tx_log[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model state: bytes collected so far, idle cycles, pending response bytes.
    int          m_n = 0;
    int          m_idle = 0;
    bit          m_full = 1'b0;
    logic [23:0] m_cmd = '0;
    bit          m_clr = 1'b0;
    logic [7:0]  m_tx = '0;
    bit          m_trmt = 1'b0;
    bit          m_sent = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_over = 1'b0;
    logic [7:0]  pend[$];
    bit          n_clr, n_trmt, n_sent, handled, slot_full;
    int          sh;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_n = 0; m_idle = 0; m_full = 0; m_cmd = '0; m_clr = 0;
            m_tx = '0; m_trmt = 0; m_sent = 0; m_busy = 0; m_over = 0;
            pend.delete();
        end else begin
            n_clr = 0;
            if (m_full) begin
                if (clr_cmd_rdy) begin m_full = 0; m_n = 0; end
            end else begin
                if (m_n > 0 && m_idle == int'(TO) - 1) begin m_n = 0; m_idle = 0; end
                if (rx_rdy && !m_clr) begin
                    sh    = 8 * (CMD_BYTES - 1 - m_n);
                    m_cmd = (m_cmd & ~(24'hFF << sh)) | (24'(rx_data) << sh);
                    m_n++;
                    m_idle = 0;
                    n_clr  = 1;
                    if (m_n == CMD_BYTES) begin m_full = 1; m_n = 0; end
                end else if (m_n > 0) m_idle++;
                else m_idle = 0;
            end
            m_clr = n_clr;

            n_trmt = 0; n_sent = 0; handled = 0;
            if (!m_busy) begin
                if (send_resp) begin m_tx = resp_data; n_trmt = 1; m_busy = 1; end
            end else begin
                slot_full = pend.size() > 0;
                if (tx_done) begin
                    n_sent = 1;
                    if (slot_full) begin m_tx = pend.pop_front(); n_trmt = 1; end
                    else if (send_resp) begin m_tx = resp_data; n_trmt = 1; handled = 1; end
                    else m_busy = 0;
                end
                if (send_resp && !handled) begin
                    if (slot_full) m_over = 1;
                    else pend.push_back(resp_data);
                end
            end
            m_trmt = n_trmt;
            m_sent = n_sent;
        end
    end

    // Per-cycle comparison plus rx/tx monitors.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("cmd", 32'(cmd), 32'(m_cmd));
            chk("cmd_rdy", 32'(cmd_rdy), 32'(m_full));
            chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(m_clr));
            chk("tx_data", 32'(tx_data), 32'(m_tx));
            chk("trmt", 32'(trmt), 32'(m_trmt));
            chk("resp_sent", 32'(resp_sent), 32'(m_sent));
            chk("resp_overrun", 32'(resp_overrun), 32'(m_over));
        end
        if (clr_rx_rdy === 1'b1) clr_cnt++;
        if (trmt === 1'b1) tx_log.push_back(tx_data);
    end

    task automatic send_byte(input logic [7:0] b);
        bit seen;
        seen = 0;
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) seen = 1;
        end
        rx_rdy = 1'b0;
        chk("rx_handshake", 32'(seen), 32'd1);
    endtask

    task automatic clear_cmd();
        @(negedge clk); clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
        chk("cmd_rdy_cleared", 32'(cmd_rdy), 32'd0);
    endtask

    task automatic send_rsp(input logic [7:0] b);
        @(negedge clk); resp_data = b; send_resp = 1'b1;
        @(negedge clk); send_resp = 1'b0;
    endtask

    task automatic tx_pulse();
        @(negedge clk); tx_done = 1'b1;
        @(negedge clk); tx_done = 1'b0;
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("rst_trmt", 32'(trmt), 32'd0);
        chk("rst_overrun", 32'(resp_overrun), 32'd0);
        #2 rst_n = 1'b1;

        // 1) basic three-byte command
        clr_cnt = 0;
        send_byte(8'h02); send_byte(8'h05); send_byte(8'h1A);
        chk("t1_cmd", 32'(cmd), 32'h02051A);
        chk("t1_cmd_rdy", 32'(cmd_rdy), 32'd1);
        repeat (4) @(negedge clk);
        chk("t1_clr_pulses", 32'(clr_cnt), 32'd3);
        chk("t1_cmd_rdy_held", 32'(cmd_rdy), 32'd1);
        clear_cmd();

        // 2) byte arriving while a command is pending waits for clr_cmd_rdy
        send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
        @(negedge clk); rx_data = 8'h09; rx_rdy = 1'b1;
        clr_cnt = 0;
        repeat (6) @(negedge clk);
        chk("t2_no_consume", 32'(clr_cnt), 32'd0);
        clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
        seen = 0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) seen = 1;
        end
        rx_rdy = 1'b0;
        chk("t2_consumed", 32'(seen), 32'd1);
        chk("t2_cmd", 32'(cmd), 32'h090B0C);
        chk("t2_cmd_rdy", 32'(cmd_rdy), 32'd0);
        repeat (20) @(negedge clk);

        // 3) partial command discarded after inter-byte timeout
        send_byte(8'h08);
        repeat (20) @(negedge clk);
        send_byte(8'h09); send_byte(8'h00); send_byte(8'h03);
        chk("t3_cmd", 32'(cmd), 32'h090003);
        chk("t3_cmd_rdy", 32'(cmd_rdy), 32'd1);
        clear_cmd();

        // 3b) byte presented exactly as the timeout fires becomes byte 0
        send_byte(8'h44);
        repeat (14) @(negedge clk);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        chk("t3b_cmd", 32'(cmd), 32'h556677);
        chk("t3b_cmd_rdy", 32'(cmd_rdy), 32'd1);
        clear_cmd();

        // 4) single response
        tx_log.delete();
        send_rsp(RESP_ACK);
        chk("t4_trmt", 32'(trmt), 32'd1);
        chk("t4_tx_data", 32'(tx_data), 32'hA5);
        repeat (100) @(negedge clk);
        tx_pulse();
        chk("t4_resp_sent", 32'(resp_sent), 32'd1);
        @(negedge clk);
        chk("t4_resp_sent_once", 32'(resp_sent), 32'd0);
        chk("t4_log_size", 32'(tx_log.size()), 32'd1);

        // 5) holding slot and overrun
        tx_log.delete();
        @(negedge clk); resp_data = RESP_ACK;  send_resp = 1'b1;
        @(negedge clk); resp_data = RESP_NACK;
        @(negedge clk); resp_data = 8'h3C;
        @(negedge clk); send_resp = 1'b0;
        chk("t5_overrun", 32'(resp_overrun), 32'd1);
        repeat (10) @(negedge clk);
        tx_pulse();
        repeat (10) @(negedge clk);
        tx_pulse();
        repeat (5) @(negedge clk);
        chk("t5_log_size", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() == 2) begin
            chk("t5_log0", 32'(tx_log[0]), 32'hA5);
            chk("t5_log1", 32'(tx_log[1]), 32'hEE);
        end
        chk("t5_overrun_sticky", 32'(resp_overrun), 32'd1);

        // 6) reset mid-command and mid-transmit
        send_byte(8'h31); send_byte(8'h32);
        send_rsp(8'h5A);
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_cmd", 32'(cmd), 32'd0);
        chk("t6_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("t6_clr", 32'(clr_rx_rdy), 32'd0);
        chk("t6_tx_data", 32'(tx_data), 32'd0);
        chk("t6_trmt", 32'(trmt), 32'd0);
        chk("t6_sent", 32'(resp_sent), 32'd0);
        chk("t6_overrun", 32'(resp_overrun), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk("t6_clean_cmd", 32'(cmd), 32'h112233);
        clear_cmd();

        // 7) request coinciding with tx_done and an empty slot is sent next
        tx_log.delete();
        send_rsp(8'h77);
        repeat (5) @(negedge clk);
        @(negedge clk); tx_done = 1'b1; send_resp = 1'b1; resp_data = 8'h88;
        @(negedge clk); tx_done = 1'b0; send_resp = 1'b0;
        chk("t7_trmt", 32'(trmt), 32'd1);
        chk("t7_tx_data", 32'(tx_data), 32'h88);
        repeat (5) @(negedge clk);
        tx_pulse();
        repeat (3) @(negedge clk);
        chk("t7_log_size", 32'(tx_log.size()), 32'd2);
        chk("t7_overrun", 32'(resp_overrun), 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
